// File: rtl/mem_lsu_if.sv
`default_nettype none
// ============================================================================
// mem_lsu_if : request/response handshake and data-RAM bus of the load/store unit
// Rev 1.0
// ============================================================================
interface mem_lsu_if #(
    parameter int TAG_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [31:0]      req_addr;
    logic [31:0]      req_wdata;
    logic [TAG_W-1:0] req_tag;

    logic             resp_valid;
    logic             resp_ready;
    logic [31:0]      resp_data;
    logic             resp_err;
    logic [TAG_W-1:0] resp_tag;

    logic [31:0]      addr_mem;
    logic [31:0]      w_data_mem;
    logic [3:0]       w_en_mem;
    logic             en_mem;
    logic [31:0]      r_data_mem;

    // Pipeline plus data RAM: issues requests, consumes responses, returns read data.
    modport master (
        output req_valid, req_op, req_addr, req_wdata, req_tag,
        output resp_ready, r_data_mem,
        input  req_ready, resp_valid, resp_data, resp_err, resp_tag,
        input  addr_mem, w_data_mem, w_en_mem, en_mem
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, req_tag,
        input  resp_ready, r_data_mem,
        output req_ready, resp_valid, resp_data, resp_err, resp_tag,
        output addr_mem, w_data_mem, w_en_mem, en_mem
    );
endinterface
`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
// mem_lsu : byte/half/word load-store unit in front of a 1-cycle sync-read RAM
// Rev 1.0
// ============================================================================
module mem_lsu #(
    parameter bit BIG_ENDIAN = 1'b1,
    parameter int TAG_W      = 5
) (
    input  wire logic clk,
    input  wire logic rst,
    mem_lsu_if.slave  lsu_io
);
    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LBU = 3'd1;
    localparam logic [2:0] OP_LH  = 3'd2;
    localparam logic [2:0] OP_LHU = 3'd3;
    localparam logic [2:0] OP_LW  = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RESP = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t           state_q;
    logic [2:0]       op_q;
    logic [1:0]       off_q;
    logic [TAG_W-1:0] tag_q;
    logic             err_q;
    logic [31:0]      hold_q;

    logic        w_req_ready;
    logic        w_accept;
    logic        w_go;
    logic        w_is_store;
    logic        w_is_half;
    logic        w_is_word;
    logic        w_misalign;
    logic [3:0]  w_lanes;
    logic [31:0] w_repl;
    logic [31:0] w_fmt;

    function automatic logic [31:0] fmt_load(input logic [31:0] word,
                                             input logic [2:0]  op,
                                             input logic [1:0]  off);
        logic [1:0]  bsel;
        logic        hsel;
        logic [31:0] bsh;
        logic [31:0] hsh;
        logic [31:0] res;
        bsel = BIG_ENDIAN ? ~off : off;
        hsel = BIG_ENDIAN ? ~off[1] : off[1];
        bsh  = word >> {bsel, 3'b000};
        hsh  = word >> {hsel, 4'b0000};
        case (op)
            OP_LB:   res = {{24{bsh[7]}}, bsh[7:0]};
            OP_LBU:  res = {24'd0, bsh[7:0]};
            OP_LH:   res = {{16{hsh[15]}}, hsh[15:0]};
            OP_LHU:  res = {16'd0, hsh[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    always_comb begin
        w_is_store  = (lsu_io.req_op == OP_SB) || (lsu_io.req_op == OP_SH) ||
                      (lsu_io.req_op == OP_SW);
        w_is_half   = (lsu_io.req_op == OP_LH) || (lsu_io.req_op == OP_LHU) ||
                      (lsu_io.req_op == OP_SH);
        w_is_word   = (lsu_io.req_op == OP_LW) || (lsu_io.req_op == OP_SW);
        w_misalign  = (w_is_half && lsu_io.req_addr[0]) ||
                      (w_is_word && (lsu_io.req_addr[1:0] != 2'b00));
        w_req_ready = !rst && ((state_q == S_IDLE) || lsu_io.resp_ready);
        w_accept    = lsu_io.req_valid && w_req_ready;
        w_go        = w_accept && !w_misalign;

        w_lanes = 4'b1111;
        w_repl  = lsu_io.req_wdata;
        case (lsu_io.req_op)
            OP_SB: begin
                w_lanes = BIG_ENDIAN ? (4'b1000 >> lsu_io.req_addr[1:0])
                                     : (4'b0001 << lsu_io.req_addr[1:0]);
                w_repl  = {4{lsu_io.req_wdata[7:0]}};
            end
            OP_SH: begin
                w_lanes = (lsu_io.req_addr[1] ^ BIG_ENDIAN) ? 4'b1100 : 4'b0011;
                w_repl  = {2{lsu_io.req_wdata[15:0]}};
            end
            default: ;
        endcase

        // Stores and faulted accesses return zero data; loads use the RAM word of this cycle.
        w_fmt = (err_q || (op_q >= OP_SB)) ? 32'd0 : fmt_load(lsu_io.r_data_mem, op_q, off_q);
    end

    assign lsu_io.req_ready  = w_req_ready;
    assign lsu_io.en_mem     = w_go;
    assign lsu_io.w_en_mem   = (w_go && w_is_store) ? w_lanes : 4'b0000;
    assign lsu_io.addr_mem   = w_accept ? {lsu_io.req_addr[31:2], 2'b00} : 32'd0;
    assign lsu_io.w_data_mem = (w_accept && w_is_store) ? w_repl : 32'd0;

    assign lsu_io.resp_valid = (state_q != S_IDLE);
    assign lsu_io.resp_data  = (state_q == S_RESP) ? w_fmt :
                               (state_q == S_HOLD) ? hold_q : 32'd0;
    assign lsu_io.resp_err   = (state_q != S_IDLE) ? err_q : 1'b0;
    assign lsu_io.resp_tag   = (state_q != S_IDLE) ? tag_q : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= 3'd0;
            off_q   <= 2'd0;
            tag_q   <= '0;
            err_q   <= 1'b0;
            hold_q  <= 32'd0;
        end else begin
            if (w_accept) begin
                op_q  <= lsu_io.req_op;
                off_q <= lsu_io.req_addr[1:0];
                tag_q <= lsu_io.req_tag;
                err_q <= w_misalign;
            end
            // The RAM output is only trusted in RESP, so snapshot the result there.
            if (state_q == S_RESP) begin
                hold_q <= w_fmt;
            end
            case (state_q)
                S_IDLE: begin
                    if (w_accept) state_q <= S_RESP;
                end
                S_RESP, S_HOLD: begin
                    if (lsu_io.resp_ready) state_q <= w_accept ? S_RESP : S_IDLE;
                    else                   state_q <= S_HOLD;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// ============================================================================
// tb_mem_lsu : randomized scoreboard bench for mem_lsu against a byte-array model
// Rev 1.0
// ============================================================================
module tb_mem_lsu;
    localparam int TAG_W = 5;
    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LBU = 3'd1;
    localparam logic [2:0] OP_LH  = 3'd2;
    localparam logic [2:0] OP_LHU = 3'd3;
    localparam logic [2:0] OP_LW  = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    typedef struct packed {
        logic [31:0]      data;
        logic             err;
        logic [TAG_W-1:0] tag;
    } resp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_lsu_if #(.TAG_W(TAG_W)) bus ();
    mem_lsu #(.BIG_ENDIAN(1'b1), .TAG_W(TAG_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .lsu_io (bus)
    );

    int    checks = 0;
    int    fails  = 0;
    resp_t exp_q[$];
    logic [7:0]  bm [0:63];
    logic [31:0] ram [0:15];
    bit    ram_init = 1'b1;
    bit    mon_on   = 1'b0;
    bit    rand_rr  = 1'b0;
    logic  rr_man   = 1'b1;
    logic  rr_rand  = 1'b1;

    assign bus.resp_ready = rand_rr ? rr_rand : rr_man;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int w);
        logic [31:0] v;
        v = 32'h9E3779B9 * (w + 1);
        if (w == 4) v = 32'h80FF7F01;
        return v;
    endfunction

    function automatic int op_size(input logic [2:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 1;
            OP_LH, OP_LHU, OP_SH: return 2;
            default:              return 4;
        endcase
    endfunction

    // Data RAM: 16 words, read-first, output scrambled whenever it is not enabled.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int w = 0; w < 16; w++) ram[w] <= init_word(w);
        end else if (bus.en_mem) begin
            bus.r_data_mem <= ram[bus.addr_mem[5:2]];
            for (int i = 0; i < 4; i++)
                if (bus.w_en_mem[i]) ram[bus.addr_mem[5:2]][8*i +: 8] <= bus.w_data_mem[8*i +: 8];
        end else begin
            bus.r_data_mem <= $urandom;
        end
    end

    always @(posedge clk) begin
        #1;
        rr_rand = ($urandom_range(0, 3) != 0);
    end

    // Handshake monitor: a response is owed from acceptance until it is consumed.
    bit busy = 1'b0;
    always @(negedge clk) begin
        if (mon_on) begin
            chk("req_ready", {31'd0, bus.req_ready}, {31'd0, !rst && (!busy || bus.resp_ready)});
            chk("resp_valid", {31'd0, bus.resp_valid}, {31'd0, busy});
            if (!(bus.req_valid && bus.req_ready)) begin
                chk("idle_ctl", {27'd0, bus.en_mem, bus.w_en_mem}, 32'd0);
                chk("idle_addr", bus.addr_mem, 32'd0);
                chk("idle_wdata", bus.w_data_mem, 32'd0);
            end
            busy = rst ? 1'b0 : ((bus.req_valid && bus.req_ready) || (busy && !bus.resp_ready));
        end
    end

    // Response monitor: pops the scoreboard and checks stability while stalled.
    bit               stall = 1'b0;
    logic [31:0]      pd;
    logic             pe;
    logic [TAG_W-1:0] pt;
    resp_t            got;
    always @(negedge clk) begin
        if (rst || !mon_on) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                chk("stall_data", bus.resp_data, pd);
                chk("stall_err", {31'd0, bus.resp_err}, {31'd0, pe});
                chk("stall_tag", {27'd0, bus.resp_tag}, {27'd0, pt});
            end
            if (bus.resp_valid && bus.resp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_resp: got data %h tag %0d, expected none", bus.resp_data, bus.resp_tag);
                end else begin
                    got = exp_q.pop_front();
                    chk("resp_data", bus.resp_data, got.data);
                    chk("resp_err", {31'd0, bus.resp_err}, {31'd0, got.err});
                    chk("resp_tag", {27'd0, bus.resp_tag}, {27'd0, got.tag});
                end
            end
            stall = bus.resp_valid && !bus.resp_ready;
            pd = bus.resp_data;
            pe = bus.resp_err;
            pt = bus.resp_tag;
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic drive_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                             input logic [TAG_W-1:0] tag, input bit use_c, input logic [31:0] c_data);
        int          n;
        int          sz;
        bit          mis;
        logic [3:0]  wen;
        logic [31:0] v;
        logic [31:0] t;
        resp_t       r;
        n = 0;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        bus.req_tag   = tag;
        forever begin
            @(negedge clk);
            if (bus.req_ready) break;
            n++;
            if (n > 50) begin
                checks++;
                fails++;
                $display("FAIL accept_timeout: op %0d addr %h not accepted in 50 cycles", op, a);
                bus.req_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        sz  = op_size(op);
        mis = (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
        wen = 4'b0000;
        if (op >= OP_SB && !mis)
            for (int k = 0; k < sz; k++) wen[3 - (int'(a[1:0]) + k)] = 1'b1;
        chk("en_mem", {31'd0, bus.en_mem}, {31'd0, !mis});
        chk("addr_mem", bus.addr_mem, {a[31:2], 2'b00});
        chk("w_en_mem", {28'd0, bus.w_en_mem}, {28'd0, wen});
        if (op >= OP_SB && !mis)
            chk("w_data_mem", bus.w_data_mem,
                (sz == 1) ? {4{wd[7:0]}} : (sz == 2) ? {2{wd[15:0]}} : wd);
        r.tag  = tag;
        r.err  = mis;
        r.data = 32'd0;
        if (!mis) begin
            if (op >= OP_SB) begin
                for (int k = 0; k < sz; k++) begin
                    t = wd >> (8 * (sz - 1 - k));
                    bm[int'(a[5:0]) + k] = t[7:0];
                end
            end else begin
                v = 32'd0;
                for (int k = 0; k < sz; k++) v = (v << 8) | {24'd0, bm[int'(a[5:0]) + k]};
                if (op == OP_LB && v[7])  v[31:8]  = '1;
                if (op == OP_LH && v[15]) v[31:16] = '1;
                r.data = v;
            end
        end
        if (use_c) r.data = c_data;
        exp_q.push_back(r);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [31:0] t;
        for (int w = 0; w < 16; w++) begin
            v = init_word(w);
            for (int k = 0; k < 4; k++) begin
                t = v >> (24 - 8 * k);
                bm[4 * w + k] = t[7:0];
            end
        end
        bus.req_valid = 1'b0;
        bus.req_op    = 3'd0;
        bus.req_addr  = 32'd0;
        bus.req_wdata = 32'd0;
        bus.req_tag   = '0;
        repeat (3) @(posedge clk);
        #1;
        mon_on = 1'b1;
        @(negedge clk);
        chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_resp_data", bus.resp_data, 32'd0);
        chk("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
        chk("rst_resp_tag", {27'd0, bus.resp_tag}, 32'd0);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        ram_init = 1'b0;

        // Big-endian extraction from word 0x80FF7F01 at 0x10, then store/load round trips.
        drive_req(OP_LB,  32'h11, 32'h0, 5'd1, 1'b1, 32'hFFFFFFFF);
        drive_req(OP_LBU, 32'h11, 32'h0, 5'd2, 1'b1, 32'h000000FF);
        drive_req(OP_LH,  32'h12, 32'h0, 5'd3, 1'b1, 32'h00007F01);
        drive_req(OP_LHU, 32'h10, 32'h0, 5'd4, 1'b1, 32'h000080FF);
        drive_req(OP_SW,  32'h10, 32'h11223344, 5'd5, 1'b1, 32'h0);
        drive_req(OP_LW,  32'h10, 32'h0, 5'd6, 1'b1, 32'h11223344);
        drive_req(OP_SB,  32'h13, 32'hAB, 5'd7, 1'b1, 32'h0);
        drive_req(OP_SH,  32'h12, 32'hBEEF, 5'd8, 1'b1, 32'h0);
        drive_req(OP_LW,  32'h10, 32'h0, 5'd9, 1'b1, 32'h1122BEEF);
        drive_req(OP_LW,  32'h02, 32'h0, 5'd10, 1'b1, 32'h0);
        drive_req(OP_SH,  32'h01, 32'h1234, 5'd11, 1'b1, 32'h0);
        drain();

        // Stalled consumer while the RAM output keeps changing; a second request waits.
        rr_man = 1'b0;
        drive_req(OP_LW, 32'h10, 32'h0, 5'd12, 1'b0, 32'h0);
        fork
            begin
                repeat (4) @(posedge clk);
                #1;
                rr_man = 1'b1;
            end
        join_none
        drive_req(OP_LBU, 32'h12, 32'h0, 5'd13, 1'b0, 32'h0);
        drain();

        // Reset while a load response is pending: it is dropped, then normal operation.
        rr_man = 1'b0;
        drive_req(OP_LW, 32'h14, 32'h0, 5'd14, 1'b0, 32'h0);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst    = 1'b0;
        rr_man = 1'b1;
        @(negedge clk);
        chk("post_rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        @(posedge clk);
        #1;
        drive_req(OP_LW, 32'h10, 32'h0, 5'd15, 1'b0, 32'h0);
        drain();

        rand_rr = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [2:0]  op;
            logic [31:0] a;
            int          sz;
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            sz = op_size(op);
            if ($urandom_range(0, 3) != 0)
                a[1:0] = (sz == 1) ? a[1:0] : (sz == 2) ? {a[1], 1'b0} : 2'b00;
            drive_req(op, a, $urandom, TAG_W'($urandom), 1'b0, 32'h0);
        end
        rand_rr = 1'b0;
        rr_man  = 1'b1;
        drain();
        repeat (2) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
`default_nettype wire
